// File: rtl/usb3_if_rx.sv
// -----------------------------------------------------------------------------
// usb3_if_rx
// Receive bridge from an FTDI FT60x (245 synchronous FIFO mode, 32-bit bus)
// into a dual-clock 32-bit FIFO (dc32). Everything runs on the FTDI clock.
// The FT60x RX buffer is drained in bursts. Each valid word is pushed into the
// dc32 FIFO one cycle after it is sampled. When the FIFO reports almost-full,
// reading stops. It only restarts once the FIFO has drained to empty.
//
// Ports
//   ftdi_clk               in   FT60x clock, the only clock
//   reset_n                in   synchronous active-low reset
//   FR_RXF                 in   FT60x RX-not-empty, active low
//   FT_OE                  out  FT60x bus output enable, active low
//   FT_RD                  out  FT60x read strobe, active low
//   usb3_data_in           in   FT60x data bus
//   write_to_dc32_fifo     out  dc32 write enable, one word per cycle
//   dc32_fifo_data_in      out  word written to the dc32 FIFO
//   dc32_fifo_almost_full  in   dc32 almost full (needs >= 3 words slack)
//   dc32_fifo_is_empty     in   dc32 empty, releases the throttle
//
// Parameters
//   DATA_WIDTH  bus/FIFO width, fixed at 32
//   OE_LEAD     cycles FT_OE is low before FT_RD falls, 1..3
//
// Configuration
//   USB3_IF_BYTE_SWAP_EN  when defined, each word is byte-reversed before
//                         being written; timing is unchanged.
// -----------------------------------------------------------------------------
module usb3_if_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int OE_LEAD    = 1
) (
    input  logic                  ftdi_clk,
    input  logic                  reset_n,
    input  logic                  FR_RXF,
    output logic                  FT_OE,
    output logic                  FT_RD,
    input  logic [DATA_WIDTH-1:0] usb3_data_in,
    output logic                  write_to_dc32_fifo,
    output logic [DATA_WIDTH-1:0] dc32_fifo_data_in,
    input  logic                  dc32_fifo_almost_full,
    input  logic                  dc32_fifo_is_empty
);

    typedef enum logic [2:0] {
        IDLE,
        OE_WAIT,
        READ,
        STOP,
        THROTTLE
    } state_e;

    localparam logic [1:0] LEAD_LAST = 2'(OE_LEAD - 1);

    state_e                  state_q;
    logic                    throttle_q;   // set while waiting for the FIFO to empty
    logic                    stop_af_q;    // STOP was entered because of almost-full
    logic [1:0]              lead_cnt_q;
    logic                    ft_oe_q;
    logic                    ft_rd_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    function automatic logic [DATA_WIDTH-1:0] fmt_word(input logic [DATA_WIDTH-1:0] d);
`ifdef USB3_IF_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // NOTE: every register in this block is assigned with <= so that all the
    // case branches read the values from before the clock edge.
    always_ff @(posedge ftdi_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            throttle_q <= 1'b0;
            stop_af_q  <= 1'b0;
            lead_cnt_q <= 2'd0;
            ft_oe_q    <= 1'b1;
            ft_rd_q    <= 1'b1;
            wr_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            // NOTE: the write strobe defaults low each cycle. Only a valid word
            // sampled in READ raises it, so it can never stay high.
            wr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!FR_RXF && !dc32_fifo_almost_full && !throttle_q) begin
                        state_q    <= OE_WAIT;
                        ft_oe_q    <= 1'b0;
                        lead_cnt_q <= 2'd0;
                    end
                end

                OE_WAIT: begin
                    if (FR_RXF) begin
                        // FT60x emptied before the first read: release the bus.
                        state_q   <= STOP;
                        ft_oe_q   <= 1'b1;
                        ft_rd_q   <= 1'b1;
                        stop_af_q <= 1'b0;
                    end else if (lead_cnt_q == LEAD_LAST) begin
                        state_q <= READ;
                        ft_rd_q <= 1'b0;
                    end else begin
                        lead_cnt_q <= lead_cnt_q + 2'd1;
                    end
                end

                READ: begin
                    if (!ft_rd_q && !FR_RXF) begin
                        wr_q   <= 1'b1;
                        data_q <= fmt_word(usb3_data_in);
                    end
                    // When almost-full is seen, the word on that edge is still
                    // stored, because the FT60x has already handed it over.
                    // That is one word after almost-full, inside the slack.
                    if (FR_RXF || dc32_fifo_almost_full) begin
                        state_q   <= STOP;
                        ft_oe_q   <= 1'b1;
                        ft_rd_q   <= 1'b1;
                        stop_af_q <= dc32_fifo_almost_full;
                    end
                end

                STOP: begin
                    // The throttle flag rises only after the last write strobe
                    // has retired. So no write is ever seen while it is set.
                    throttle_q <= stop_af_q;
                    state_q    <= stop_af_q ? THROTTLE : IDLE;
                end

                THROTTLE: begin
                    if (dc32_fifo_is_empty) begin
                        throttle_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign FT_OE              = ft_oe_q;
    assign FT_RD              = ft_rd_q;
    assign write_to_dc32_fifo = wr_q;
    assign dc32_fifo_data_in  = data_q;

endmodule

// File: tb/tb_usb3_if_rx.sv
// -----------------------------------------------------------------------------
// tb_usb3_if_rx
// Directed testbench for usb3_if_rx. Inputs are driven 1 time unit after the
// rising edge. Outputs are checked at that same point, which is after the edge
// they were registered on. A negative-edge monitor collects every word written
// to the FIFO. The same monitor also tracks the FT_RD/FT_OE ordering.
// -----------------------------------------------------------------------------
module tb_usb3_if_rx;

    localparam int OE_LEAD = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        FR_RXF;
    logic        FT_OE;
    logic        FT_RD;
    logic [31:0] usb3_data_in;
    logic        write_to_dc32_fifo;
    logic [31:0] dc32_fifo_data_in;
    logic        dc32_fifo_almost_full;
    logic        dc32_fifo_is_empty;

    int checks = 0;
    int errors = 0;
    int inv_viol = 0;
    logic [31:0] got_q[$];

    usb3_if_rx #(.DATA_WIDTH(32), .OE_LEAD(OE_LEAD)) dut (
        .ftdi_clk              (clk),
        .reset_n               (reset_n),
        .FR_RXF                (FR_RXF),
        .FT_OE                 (FT_OE),
        .FT_RD                 (FT_RD),
        .usb3_data_in          (usb3_data_in),
        .write_to_dc32_fifo    (write_to_dc32_fifo),
        .dc32_fifo_data_in     (dc32_fifo_data_in),
        .dc32_fifo_almost_full (dc32_fifo_almost_full),
        .dc32_fifo_is_empty    (dc32_fifo_is_empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_to_dc32_fifo === 1'b1) got_q.push_back(dc32_fifo_data_in);
        if (FT_RD === 1'b0 && FT_OE !== 1'b0) inv_viol++;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef USB3_IF_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        FR_RXF = 1'b0;
        usb3_data_in = 32'h0;
        dc32_fifo_almost_full = 1'b0;
        dc32_fifo_is_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: oe/rd/wr=%b expected 110", i,
                         {FT_OE, FT_RD, write_to_dc32_fifo});
            end
        end
        checks++;
        if (dc32_fifo_data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", dc32_fifo_data_in);
        end
        FR_RXF = 1'b1;
        reset_n = 1'b1;
        tick();
        checks++;
        if ({FT_OE, FT_RD} !== 2'b11) begin
            errors++;
            $display("FAIL reset_idle: oe/rd=%b expected 11", {FT_OE, FT_RD});
        end
    endtask

    task automatic test_burst();
        logic [31:0] words [4];
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        got_q.delete();
        FR_RXF = 1'b0;
        usb3_data_in = words[0];
        tick();  // IDLE -> OE_WAIT
        checks++;
        if ({FT_OE, FT_RD} !== 2'b01) begin
            errors++;
            $display("FAIL burst_oe_lead: oe/rd=%b expected 01", {FT_OE, FT_RD});
        end
        repeat (OE_LEAD - 1) tick();
        tick();  // OE_WAIT -> READ
        checks++;
        if ({FT_OE, FT_RD} !== 2'b00) begin
            errors++;
            $display("FAIL burst_rd_low: oe/rd=%b expected 00", {FT_OE, FT_RD});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (write_to_dc32_fifo !== 1'b1 || dc32_fifo_data_in !== exp_word(words[i])) begin
                errors++;
                $display("FAIL burst_write %0d: wr=%b data=%h expected wr=1 data=%h", i,
                         write_to_dc32_fifo, dc32_fifo_data_in, exp_word(words[i]));
            end
            if (i < 3) usb3_data_in = words[i+1];
            else FR_RXF = 1'b1;
        end
        tick();  // READ -> STOP, FT60x empty
        checks++;
        if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
            errors++;
            $display("FAIL burst_end: oe/rd/wr=%b expected 110", {FT_OE, FT_RD, write_to_dc32_fifo});
        end
        tick();  // STOP -> IDLE
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL burst_count: got %0d writes expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== exp_word(words[i])) begin
                    errors++;
                    $display("FAIL burst_order %0d: got %h expected %h", i, got_q[i], exp_word(words[i]));
                end
            end
        end
    endtask

    task automatic test_throttle();
        logic [31:0] w [10];
        for (int i = 0; i < 10; i++) w[i] = 32'hA000_0000 + 32'(i);
        got_q.delete();
        FR_RXF = 1'b0;
        dc32_fifo_almost_full = 1'b0;
        dc32_fifo_is_empty = 1'b0;
        usb3_data_in = w[0];
        tick();  // OE_WAIT
        repeat (OE_LEAD - 1) tick();
        tick();  // READ
        tick();  // w0 written
        usb3_data_in = w[1];
        tick();  // w1 written
        usb3_data_in = w[2];
        dc32_fifo_almost_full = 1'b1;
        tick();  // w2 written, almost-full seen
        checks++;
        if (FT_RD !== 1'b1 || write_to_dc32_fifo !== 1'b1 || dc32_fifo_data_in !== exp_word(w[2])) begin
            errors++;
            $display("FAIL thr_rd_high: rd=%b wr=%b data=%h expected rd=1 wr=1 data=%h",
                     FT_RD, write_to_dc32_fifo, dc32_fifo_data_in, exp_word(w[2]));
        end
        usb3_data_in = w[3];
        tick();  // STOP -> THROTTLE
        dc32_fifo_almost_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
                errors++;
                $display("FAIL thr_hold cycle %0d: oe/rd/wr=%b expected 110", i,
                         {FT_OE, FT_RD, write_to_dc32_fifo});
            end
        end
        checks++;
        if (got_q.size() < 2 || got_q.size() > 4) begin
            errors++;
            $display("FAIL thr_slack: got %0d writes expected 2..4 (<=2 after almost-full)", got_q.size());
        end
        // The resume below continues from w3. So all three earlier words must be present.
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL thr_pre_count: got %0d writes expected 3", got_q.size());
        end
        dc32_fifo_is_empty = 1'b1;
        tick();  // THROTTLE -> IDLE
        dc32_fifo_is_empty = 1'b0;
        tick();  // IDLE -> OE_WAIT
        checks++;
        if ({FT_OE, FT_RD} !== 2'b01) begin
            errors++;
            $display("FAIL thr_resume: oe/rd=%b expected 01", {FT_OE, FT_RD});
        end
        repeat (OE_LEAD - 1) tick();
        tick();  // READ
        for (int i = 3; i < 10; i++) begin
            tick();
            if (i < 9) usb3_data_in = w[i+1];
            else FR_RXF = 1'b1;
        end
        tick();  // STOP
        tick();  // IDLE
        checks++;
        if (got_q.size() != 10) begin
            errors++;
            $display("FAIL thr_total: got %0d writes expected 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_q[i] !== exp_word(w[i])) begin
                    errors++;
                    $display("FAIL thr_order %0d: got %h expected %h", i, got_q[i], exp_word(w[i]));
                end
            end
        end
    endtask

    task automatic test_abort();
        got_q.delete();
        FR_RXF = 1'b0;
        usb3_data_in = 32'hDEAD_BEEF;
        tick();  // OE_WAIT
        checks++;
        if (FT_OE !== 1'b0) begin
            errors++;
            $display("FAIL abort_enter: oe=%b expected 0", FT_OE);
        end
        FR_RXF = 1'b1;
        tick();  // abort -> STOP
        checks++;
        if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
            errors++;
            $display("FAIL abort_release: oe/rd/wr=%b expected 110", {FT_OE, FT_RD, write_to_dc32_fifo});
        end
        tick();  // STOP -> IDLE
        tick();
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: got %0d writes expected 0", got_q.size());
        end
        FR_RXF = 1'b0;
        tick();  // only IDLE lowers FT_OE on the next edge
        checks++;
        if (FT_OE !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: oe=%b expected 0", FT_OE);
        end
        FR_RXF = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_byte_swap();
        FR_RXF = 1'b0;
        usb3_data_in = 32'hAABB_CCDD;
        tick();
        repeat (OE_LEAD - 1) tick();
        tick();
        tick();
        checks++;
`ifdef USB3_IF_BYTE_SWAP_EN
        if (write_to_dc32_fifo !== 1'b1 || dc32_fifo_data_in !== 32'hDDCC_BBAA) begin
            errors++;
            $display("FAIL byte_swap: wr=%b data=%h expected wr=1 data=ddccbbaa",
                     write_to_dc32_fifo, dc32_fifo_data_in);
        end
`else
        if (write_to_dc32_fifo !== 1'b1 || dc32_fifo_data_in !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL byte_pass: wr=%b data=%h expected wr=1 data=aabbccdd",
                     write_to_dc32_fifo, dc32_fifo_data_in);
        end
`endif
        FR_RXF = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        FR_RXF = 1'b0;
        usb3_data_in = 32'h5555_0001;
        tick();
        repeat (OE_LEAD - 1) tick();
        tick();
        tick();  // one word in flight
        reset_n = 1'b0;
        usb3_data_in = 32'h5555_0002;
        tick();
        checks++;
        if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110 || dc32_fifo_data_in !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: oe/rd/wr=%b data=%h expected 110 data=00000000",
                     {FT_OE, FT_RD, write_to_dc32_fifo}, dc32_fifo_data_in);
        end
        FR_RXF = 1'b1;
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
            errors++;
            $display("FAIL mid_reset_idle: oe/rd/wr=%b expected 110", {FT_OE, FT_RD, write_to_dc32_fifo});
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_throttle();
        test_abort();
        test_byte_swap();
        test_mid_reset();
        checks++;
        if (inv_viol != 0) begin
            errors++;
            $display("FAIL rd_without_oe: %0d cycles with FT_RD low and FT_OE high, expected 0", inv_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
